// File: rtl/stage_id_pkg.sv
// Shared decode constants for the instruction-decode stage: opcodes, ALUOp
// classes, control-bit positions, the NOP word and the main control decoder.
package stage_id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Bit positions inside the 8-bit control bundle, MSB first.
    localparam int CTRL_REGDST   = 7;
    localparam int CTRL_ALUSRC   = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_BRANCH   = 1;
    localparam int CTRL_JUMP     = 0;

    localparam logic [31:0] NOP_INST_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [7:0] ctrl;
        logic [1:0] alu_op;
    } decode_t;

    function automatic decode_t decode_op(input logic [5:0] op);
        decode_t d;
        d = '0;
        case (op)
            OP_RTYPE: begin
                d.ctrl[CTRL_REGDST]   = 1'b1;
                d.ctrl[CTRL_REGWRITE] = 1'b1;
                d.alu_op              = ALUOP_FUNCT;
            end
            OP_LW: begin
                d.ctrl[CTRL_ALUSRC]   = 1'b1;
                d.ctrl[CTRL_MEMTOREG] = 1'b1;
                d.ctrl[CTRL_REGWRITE] = 1'b1;
                d.ctrl[CTRL_MEMREAD]  = 1'b1;
                d.alu_op              = ALUOP_ADD;
            end
            OP_SW: begin
                d.ctrl[CTRL_ALUSRC]   = 1'b1;
                d.ctrl[CTRL_MEMWRITE] = 1'b1;
                d.alu_op              = ALUOP_ADD;
            end
            OP_BEQ: begin
                d.ctrl[CTRL_BRANCH]   = 1'b1;
                d.alu_op              = ALUOP_SUB;
            end
            OP_ADDI: begin
                d.ctrl[CTRL_ALUSRC]   = 1'b1;
                d.ctrl[CTRL_REGWRITE] = 1'b1;
                d.alu_op              = ALUOP_ADD;
            end
            OP_J: begin
                d.ctrl[CTRL_JUMP]     = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/stage_id_regfile_2r1w.sv
// 2-read/1-write register file with asynchronous clear; r0 is hard-wired to 0.
// Defining REGFILE_BYPASS_EN makes reads of the register being written return the new data.
module stage_id_regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [2**REG_AW];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**REG_AW; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
`ifdef REGFILE_BYPASS_EN
        // Write-first: a same-cycle write-back is visible to the decode read.
        if (we && raddr1 != '0 && raddr1 == waddr) rdata1 = wdata;
        if (we && raddr2 != '0 && raddr2 == waddr) rdata2 = wdata;
`endif
    end

endmodule

// File: rtl/stage_id.sv
// Instruction-decode stage: IF/ID register, register file, control decode,
// load-use stall and branch flush. Optional write-first bypass: REGFILE_BYPASS_EN.
module stage_id
    import stage_id_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          REG_AW   = 5,
    parameter logic [31:0] NOP_INST = NOP_INST_WORD
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       IF_PC,
    input  logic [31:0]       IF_PC4,
    input  logic [31:0]       IF_Inst,
    input  logic [3:0]        IF_InstNum,
    input  logic [3:0]        IF_InstType,
    input  logic              Flush,
    input  logic              WB_RegWrite,
    input  logic [REG_AW-1:0] WB_WriteReg,
    input  logic [DATA_W-1:0] WB_WriteData,
    output logic              Stall,
    output logic              IDEX_Valid,
    output logic [31:0]       IDEX_PC4,
    output logic [DATA_W-1:0] IDEX_ReadData1,
    output logic [DATA_W-1:0] IDEX_ReadData2,
    output logic [DATA_W-1:0] IDEX_Imm,
    output logic [REG_AW-1:0] IDEX_Rs,
    output logic [REG_AW-1:0] IDEX_Rt,
    output logic [REG_AW-1:0] IDEX_Rd,
    output logic [7:0]        IDEX_Ctrl,
    output logic [1:0]        IDEX_ALUOp,
    output logic [3:0]        IDEX_InstNum,
    output logic [3:0]        IDEX_InstType
);

    // Handshake: IDEX_Valid qualifies every IDEX_* field for one cycle and execute
    // always accepts; the only back-pressure is Stall, which tells fetch to hold.
    logic [31:0]       ifid_pc;
    logic [31:0]       ifid_pc4;
    logic [31:0]       ifid_inst;
    logic [3:0]        ifid_num;
    logic [3:0]        ifid_type;
    logic              ifid_valid;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [DATA_W-1:0] read_data1, read_data2, imm_ext;
    decode_t           dec;
    logic              issue;
    logic              unused_pc;

    assign rs        = ifid_inst[21 +: REG_AW];
    assign rt        = ifid_inst[16 +: REG_AW];
    assign rd        = ifid_inst[11 +: REG_AW];
    assign dec       = decode_op(ifid_inst[31:26]);
    assign imm_ext   = {{(DATA_W-16){ifid_inst[15]}}, ifid_inst[15:0]};
    assign unused_pc = ^ifid_pc;

    // A flush squashes everything younger, so it overrides the load-use hold.
    assign Stall = !Flush && IDEX_Valid && IDEX_Ctrl[CTRL_MEMREAD] && (IDEX_Rt != '0)
                   && ((IDEX_Rt == rs) || (IDEX_Rt == rt));

    assign issue = ifid_valid && !Flush && !Stall;

    stage_id_regfile_2r1w #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clock  (clock),
        .reset  (reset),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (read_data1),
        .rdata2 (read_data2),
        .we     (WB_RegWrite),
        .waddr  (WB_WriteReg),
        .wdata  (WB_WriteData)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ifid_pc    <= '0;
            ifid_pc4   <= '0;
            ifid_inst  <= NOP_INST;
            ifid_num   <= '0;
            ifid_type  <= '0;
            ifid_valid <= 1'b0;
        end else if (Flush) begin
            ifid_pc    <= '0;
            ifid_pc4   <= '0;
            ifid_inst  <= NOP_INST;
            ifid_num   <= '0;
            ifid_type  <= '0;
            ifid_valid <= 1'b0;
        end else if (!Stall) begin
            ifid_pc    <= IF_PC;
            ifid_pc4   <= IF_PC4;
            ifid_inst  <= IF_Inst;
            ifid_num   <= IF_InstNum;
            ifid_type  <= IF_InstType;
            ifid_valid <= 1'b1;
        end
    end

    // Bubbles (flush, stall, empty IF/ID) drive every ID/EX field to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            IDEX_Valid     <= 1'b0;
            IDEX_PC4       <= '0;
            IDEX_ReadData1 <= '0;
            IDEX_ReadData2 <= '0;
            IDEX_Imm       <= '0;
            IDEX_Rs        <= '0;
            IDEX_Rt        <= '0;
            IDEX_Rd        <= '0;
            IDEX_Ctrl      <= '0;
            IDEX_ALUOp     <= '0;
            IDEX_InstNum   <= '0;
            IDEX_InstType  <= '0;
        end else begin
            IDEX_Valid     <= issue;
            IDEX_PC4       <= issue ? ifid_pc4   : '0;
            IDEX_ReadData1 <= issue ? read_data1 : '0;
            IDEX_ReadData2 <= issue ? read_data2 : '0;
            IDEX_Imm       <= issue ? imm_ext    : '0;
            IDEX_Rs        <= issue ? rs         : '0;
            IDEX_Rt        <= issue ? rt         : '0;
            IDEX_Rd        <= issue ? rd         : '0;
            IDEX_Ctrl      <= issue ? dec.ctrl   : '0;
            IDEX_ALUOp     <= issue ? dec.alu_op : '0;
            IDEX_InstNum   <= issue ? ifid_num   : '0;
            IDEX_InstType  <= issue ? ifid_type  : '0;
        end
    end

endmodule

// File: doc/stage_id.md
Name: stage_id

Overview:
- Instruction-decode stage of the five-stage pipeline; sits directly downstream of the fetch stage.
- Owns the IF/ID pipeline register, the 32-entry register file, the main control decoder and load-use hazard detection.
- Produces the registered ID/EX bundle consumed by the execute stage.
- Accepts a write-back port from WB and a flush from EX/MEM on a taken branch.

Parameters:
- DATA_W, 32, datapath and register width
- REG_AW, 5, register-file address width (2**REG_AW entries)
- NOP_INST, 32'h00000000, instruction word loaded into IF/ID on reset or flush

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- IF_PC  in  32  PC of the fetched instruction
- IF_PC4  in  32  PC+1 from fetch (word addressed)
- IF_Inst  in  32  fetched instruction word
- IF_InstNum  in  4  instruction sequence tag
- IF_InstType  in  4  instruction class tag
- Flush  in  1  taken branch at EX/MEM; squash IF/ID and ID/EX
- WB_RegWrite  in  1  write-back enable
- WB_WriteReg  in  5  write-back destination
- WB_WriteData  in  32  write-back data
- Stall  out  1  combinational; fetch must hold its PC this cycle
- IDEX_Valid  out  1  ID/EX holds a real instruction
- IDEX_PC4  out  32  latched PC+1
- IDEX_ReadData1  out  32  rs value
- IDEX_ReadData2  out  32  rt value
- IDEX_Imm  out  32  sign-extended Inst[15:0]
- IDEX_Rs, IDEX_Rt, IDEX_Rd  out  5 each  register fields
- IDEX_Ctrl  out  8  {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, Jump}
- IDEX_ALUOp  out  2  ALU op class (00 add, 01 sub, 10 funct-decoded)
- IDEX_InstNum, IDEX_InstType  out  4 each  tags passed through

Behaviour:
- Reset (async, on assertion):
  - IF/ID loads NOP_INST, PC and PC4 0, tags 0, valid 0.
  - All IDEX_* outputs go to 0.
  - Register file clears to 0.
  - Stall is 0 while in reset.
- Latency: an instruction in IF/ID at edge n appears on IDEX_* after edge n+1. Each stage adds one cycle.
- Decode, by opcode Inst[31:26]:
  - 000000 R-type: RegDst, RegWrite, ALUOp=10.
  - 100011 lw: ALUSrc, MemToReg, RegWrite, MemRead, ALUOp=00.
  - 101011 sw: ALUSrc, MemWrite, ALUOp=00.
  - 000100 beq: Branch, ALUOp=01.
  - 001000 addi: ALUSrc, RegWrite, ALUOp=00.
  - 000010 j: Jump.
  - Any other opcode: all control 0 (bubble).
- Register file:
  - Two combinational reads, addressed by Inst[25:21] and Inst[20:16].
  - Write occurs on the rising edge when WB_RegWrite=1 and WB_WriteReg!=0.
  - r0 always reads 0; writes to r0 are ignored.
- Load-use hazard:
  - Stall=1 when IDEX_Valid & IDEX_Ctrl.MemRead & IDEX_Rt!=0 & (IDEX_Rt==IF/ID rs | IDEX_Rt==IF/ID rt).
  - On a stall: IF/ID holds its contents; ID/EX loads a bubble (valid 0, Ctrl 0); data fields don't-care but driven 0.
  - Stall lasts exactly one cycle per load-use pair.
- Flush:
  - IF/ID loads NOP_INST with valid 0; ID/EX loads a bubble.
  - Flush has priority over Stall. Stall is forced to 0 while Flush=1.
- Simultaneous WB write and ID read of the same register: without the optional feature, the read returns the old value.
- Reset asserted mid-operation clears all state immediately; first valid IDEX output appears two edges after release.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read whose address equals WB_WriteReg while WB_RegWrite=1 and address!=0 returns WB_WriteData in the same cycle (write-first).
- Undefined: the read returns the stored (old) value, and WB must complete a cycle earlier for correctness.

Decomposition:
- Shared include Definitions.vh holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - ALUOp encodings
  - Ctrl bit-index constants
  - NOP_INST value
- One sub-module: regfile_2r1w (32x32, async clear, optional bypass). Decoder and hazard logic stay inline.

Test Plan:
- Reset: hold reset 3 cycles, IF_Inst=32'h8C010004 -> all IDEX_* 0, Stall 0; release -> after 2 edges IDEX_Valid=1, Ctrl=8'b0111_1000 (lw), Imm=4.
- Write-back then read: WB writes r5=32'hDEADBEEF; next cycle decode add r3,r5,r0 -> IDEX_ReadData1=32'hDEADBEEF, ReadData2=0.
- r0 write: WB writes r0=32'h1234 -> a later read of r0 returns 0.
- Load-use: lw r2,0(r1) followed by add r4,r2,r3 -> Stall=1 for exactly one cycle, a bubble (Valid 0) is inserted, then add issues with IDEX_Rs=2.
- Flush during stall: apply the load-use pair and assert Flush in the stall cycle -> Stall=0, the next IDEX_Valid=0 and IF/ID holds NOP_INST.
- Same-cycle WB/read of r7 (WB data 32'hA5A5A5A5, stored value 32'h1): with REGFILE_BYPASS_EN -> ReadData=32'hA5A5A5A5; without -> 32'h1.
